fetch_seq_mc: RTL and testbench
===============================

Name: fetch_seq_mc

Overview:
Multi-channel successor to the single-buffer tile fetch generator. It serves NUM_CH on-chip buffers that share one BRAM read port. Each channel keeps its own tile pointer with wrap-around. The block issues NUM_FETCHES reads per tile, can be stalled by downstream backpressure, and delays bram_en by READ_LAT so that rd_valid, rd_ch and rd_last line up with BRAM read data. It sits between the arbiter control FSM and the shared weight/activation BRAM.

Parameters:
NUM_CH, 4, number of buffer channels (>=1)
NUM_FETCHES, 2, BRAM reads per tile (>=1)
NUM_TILES, 384, tiles per channel; the pointer wraps after NUM_TILES-1
CH_STRIDE, 1024, address offset between channel regions (words)
ADDR_WIDTH, 12, BRAM address width
READ_LAT, 2, BRAM read latency in cycles (>=1)
CH_W, $clog2(NUM_CH) min 1, channel index width (derived localparam)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  tile fetch request
start_ch  in  CH_W  channel for the request
start_ready  out  1  block can accept a request
ptr_clr  in  NUM_CH  per-channel pointer clear, one bit per channel
stall  in  1  downstream not ready; suppresses issue this cycle
bram_addr  out  ADDR_WIDTH  read address
bram_en  out  1  read enable
rd_valid  out  1  BRAM data valid this cycle
rd_ch  out  CH_W  channel of the returning data
rd_last  out  1  last beat of the tile
fetch_done  out  1  one-cycle pulse, equal to rd_valid & rd_last
done_ch  out  CH_W  channel that completed (= rd_ch)
wrap  out  1  one-cycle pulse when a channel pointer wraps NUM_TILES-1 -> 0

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; all pointers, offset and pipeline cleared; every output 0 except start_ready, which is 1 after reset. Reset mid-tile drops all in-flight beats and emits no fetch_done.
- FSM states:
  - IDLE: start_ready=1. If start_valid, latch start_ch -> ISSUE.
  - ISSUE: start_ready=0. When stall=0: bram_en=1 and offset++. When the beat with offset==NUM_FETCHES-1 issues -> DRAIN. When stall=1: bram_en=0, offset holds, state holds.
  - DRAIN: start_ready=0. Wait until the last beat exits the pipeline (fetch_done) -> IDLE.
  - Illegal encodings -> IDLE.
- Address (combinational from registered state): bram_addr = ch*CH_STRIDE + ptr[ch]*NUM_FETCHES + offset. Compute in 32 bits and truncate to ADDR_WIDTH. The implementation includes a simulation-only assertion that NUM_CH*CH_STRIDE <= 2^ADDR_WIDTH and NUM_TILES*NUM_FETCHES <= CH_STRIDE.
- Pointer update: ptr[ch] advances in the cycle the last beat issues. If ptr==NUM_TILES-1 it goes to 0 and wrap pulses in that same cycle.
- ptr_clr[i] clears ptr[i] next cycle. Clear wins over a simultaneous advance on the same channel; wrap is still suppressed in that case. Clearing the active channel mid-tile does not change the address of beats still being issued (the base pointer is latched at request accept).
- Return pipeline: a READ_LAT-deep shift register of {valid, ch, last} fed by the issue signals. rd_valid first asserts READ_LAT cycles after the first bram_en.
- Latency: request accept at cycle t -> first bram_en at t+1 (if no stall). With no stall, fetch_done arrives at t+NUM_FETCHES+READ_LAT and start_ready returns at t+NUM_FETCHES+READ_LAT+1.
- stall affects issue only; beats already in flight still return.
- A start_valid while start_ready=0 is ignored. The requester must hold start_valid until it is accepted.
- start_ch >= NUM_CH is ignored (not accepted); a simulation assertion flags it.

Decomposition:
- Shared package fetch_pkg holds the FSM state encoding (IDLE/ISSUE/DRAIN) and a helper function for the channel-index width.
- One sub-module, fetch_lat_pipe: a parameterised READ_LAT-deep valid/tag delay line with async reset. It is reusable by the other arbiter fetch paths.

Test Plan:
- Reset, then start ch=0 (NUM_FETCHES=2, READ_LAT=2) -> bram_addr 0,1 on consecutive cycles; rd_valid 2 cycles later with rd_last on the 2nd beat; fetch_done=1 with done_ch=0; start_ready back 1 cycle after that.
- Start ch=2 three times -> addresses 2048/2049, 2050/2051, 2052/2053; ptr[2]=3; ch0/1/3 pointers unchanged.
- NUM_TILES=3: fetch ch=1 three times -> wrap pulses on the 3rd tile's last issue; 4th fetch addresses 1024/1025.
- stall high for 3 cycles after the first beat of ch=0 -> bram_en low those 3 cycles; 2nd address unchanged; rd beats spaced 4 cycles apart; single fetch_done.
- ptr_clr[3] asserted in the same cycle as the last issue on ch=3 (ptr=5) -> ptr[3]=0 and no wrap; next fetch addresses 3072/3073.
- rst_n pulled low in DRAIN with beats in flight -> rd_valid/fetch_done stay 0; all pointers 0; start_ready=1 after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM encoding and width helper for the fetch sequencer
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Index width for n items, never narrower than one bit
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fetch_seq_mc_if.sv
// rtl/fetch_seq_mc_if.sv - request, BRAM read and return signals of the multi-channel fetch sequencer
interface fetch_seq_mc_if #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 12
);
    localparam int CH_W = fetch_pkg::ch_width(NUM_CH);

    logic                  start_valid;
    logic [CH_W-1:0]       start_ch;
    logic                  start_ready;
    logic [NUM_CH-1:0]     ptr_clr;
    logic                  stall;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_en;
    logic                  rd_valid;
    logic [CH_W-1:0]       rd_ch;
    logic                  rd_last;
    logic                  fetch_done;
    logic [CH_W-1:0]       done_ch;
    logic                  wrap;

    modport master (
        output start_valid, start_ch, ptr_clr, stall,
        input  start_ready, bram_addr, bram_en, rd_valid, rd_ch, rd_last,
               fetch_done, done_ch, wrap
    );

    modport slave (
        input  start_valid, start_ch, ptr_clr, stall,
        output start_ready, bram_addr, bram_en, rd_valid, rd_ch, rd_last,
               fetch_done, done_ch, wrap
    );
endinterface

// File: rtl/fetch_lat_pipe.sv
// rtl/fetch_lat_pipe.sv - DEPTH-cycle valid/tag delay line matching a fixed read latency
module fetch_lat_pipe #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);
    logic [DEPTH-1:0] vld;
    logic [TAG_W-1:0] tag [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            tag[0] <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_tag   = tag[DEPTH-1];
endmodule

// File: rtl/fetch_seq_mc.sv
// rtl/fetch_seq_mc.sv - per-channel tile fetch generator sharing one BRAM read port
module fetch_seq_mc
    import fetch_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int NUM_FETCHES = 2,
    parameter int NUM_TILES   = 384,
    parameter int CH_STRIDE   = 1024,
    parameter int ADDR_WIDTH  = 12,
    parameter int READ_LAT    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_seq_mc_if.slave bus
);
    localparam int CH_W  = ch_width(NUM_CH);
    localparam int PTR_W = ch_width(NUM_TILES);
    localparam int OFF_W = ch_width(NUM_FETCHES);

    fetch_state_e     state, next_state;
    logic [CH_W-1:0]  cur_ch;
    logic [PTR_W-1:0] base_ptr;
    logic [OFF_W-1:0] offset;
    logic [PTR_W-1:0] ptr [NUM_CH];
    logic             accept, issue, issue_last;
    logic [CH_W:0]    rd_tag;

    assign accept     = (state == ST_IDLE) && bus.start_valid && (32'(bus.start_ch) < NUM_CH);
    assign issue      = (state == ST_ISSUE) && !bus.stall;
    assign issue_last = issue && (offset == OFF_W'(NUM_FETCHES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept)          next_state = ST_ISSUE;
            ST_ISSUE: if (issue_last)      next_state = ST_DRAIN;
            ST_DRAIN: if (bus.fetch_done)  next_state = ST_IDLE;
            default:                       next_state = ST_IDLE;
        endcase
    end

    // Address uses the pointer captured at accept, so a mid-tile clear cannot move beats
    always_comb begin
        bus.start_ready = (state == ST_IDLE);
        bus.bram_en     = issue;
        bus.bram_addr   = ADDR_WIDTH'(32'(cur_ch) * CH_STRIDE
                                      + 32'(base_ptr) * NUM_FETCHES + 32'(offset));
        bus.wrap        = issue_last && (ptr[cur_ch] == PTR_W'(NUM_TILES - 1))
                          && !bus.ptr_clr[cur_ch];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch   <= '0;
            base_ptr <= '0;
            offset   <= '0;
            for (int i = 0; i < NUM_CH; i++) ptr[i] <= '0;
        end else begin
            if (accept) begin
                cur_ch   <= bus.start_ch;
                base_ptr <= ptr[bus.start_ch];
                offset   <= '0;
            end else if (issue) begin
                offset <= issue_last ? '0 : offset + OFF_W'(1);
            end
            // A clear on the same channel beats the advance
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.ptr_clr[i])
                    ptr[i] <= '0;
                else if (issue_last && (cur_ch == CH_W'(i)))
                    ptr[i] <= (ptr[i] == PTR_W'(NUM_TILES - 1)) ? '0 : ptr[i] + PTR_W'(1);
            end
        end
    end

    fetch_lat_pipe #(
        .DEPTH (READ_LAT),
        .TAG_W (CH_W + 1)
    ) u_lat_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (issue),
        .in_tag    ({cur_ch, issue_last}),
        .out_valid (bus.rd_valid),
        .out_tag   (rd_tag)
    );

    assign bus.rd_ch      = rd_tag[CH_W:1];
    assign bus.rd_last    = rd_tag[0];
    assign bus.fetch_done = bus.rd_valid & rd_tag[0];
    assign bus.done_ch    = rd_tag[CH_W:1];

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ((longint'(NUM_CH) * CH_STRIDE <= (longint'(1) << ADDR_WIDTH))
                    && (NUM_TILES * NUM_FETCHES <= CH_STRIDE))
                else $error("channel regions do not fit the address space");
            assert (!((state == ST_IDLE) && bus.start_valid) || (32'(bus.start_ch) < NUM_CH))
                else $error("start_ch out of range");
        end
    end
endmodule

// File: tb/tb_fetch_seq_mc.sv
// tb/tb_fetch_seq_mc.sv - self-checking bench for fetch_seq_mc
module tb_fetch_seq_mc;
    localparam int NUM_CH = 4;
    localparam int NF     = 2;
    localparam int NT     = 384;
    localparam int STRIDE = 1024;
    localparam int AW     = 12;
    localparam int RL     = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_seq_mc_if #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW)) bus ();

    fetch_seq_mc #(
        .NUM_CH(NUM_CH), .NUM_FETCHES(NF), .NUM_TILES(NT),
        .CH_STRIDE(STRIDE), .ADDR_WIDTH(AW), .READ_LAT(RL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    int addr_q[$], iss_cyc[$], rd_cyc[$], rd_ch_q[$], rd_last_q[$];
    int done_n, done_ch_v, done_cyc, wrap_n, wrap_cyc, acc_cyc, ready_cyc, timed_out;
    int mptr[NUM_CH];

    typedef struct {
        int          ch;
        logic [31:0] stall_map;
        logic [3:0]  clr_last;
        logic [3:0]  pre_clr;
        int          a0;
        int          wrap;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // One complete request: optional idle clear, accept, issue under a stall map, drain
    task automatic do_fetch(input int ch, input logic [31:0] stall_map,
                            input logic [3:0] clr_last, input logic [3:0] pre_clr);
        int issued;
        int idx;
        bit acc;
        logic stall_now;
        addr_q.delete(); iss_cyc.delete(); rd_cyc.delete(); rd_ch_q.delete(); rd_last_q.delete();
        done_n = 0; wrap_n = 0; done_cyc = -1; wrap_cyc = -1; acc_cyc = -1; ready_cyc = -1;
        done_ch_v = -1; timed_out = 0; issued = 0; acc = 0;
        @(negedge clk);
        bus.start_valid = 1'b0; bus.stall = 1'b0; bus.ptr_clr = pre_clr;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            bus.start_valid = !acc;
            bus.start_ch    = ch[1:0];
            idx = c - acc_cyc - 1;
            stall_now = (acc && issued < NF && idx < 32) ? stall_map[idx] : 1'b0;
            bus.stall   = stall_now;
            bus.ptr_clr = (acc && issued == NF - 1 && !stall_now) ? clr_last : 4'b0;
            #1;
            if (bus.bram_en) begin
                addr_q.push_back(int'(bus.bram_addr)); iss_cyc.push_back(c); issued++;
            end
            if (bus.rd_valid) begin
                rd_cyc.push_back(c); rd_ch_q.push_back(int'(bus.rd_ch));
                rd_last_q.push_back(int'(bus.rd_last));
            end
            if (bus.fetch_done) begin
                done_n++; done_ch_v = int'(bus.done_ch); done_cyc = c;
            end
            if (bus.wrap) begin
                wrap_n++; wrap_cyc = c;
            end
            if (!acc && bus.start_ready) begin
                acc = 1; acc_cyc = c;
            end else if (acc && done_n > 0 && bus.start_ready) begin
                ready_cyc = c;
                break;
            end
        end
        if (ready_cyc < 0) timed_out = 1;
        @(negedge clk);
        bus.start_valid = 1'b0; bus.stall = 1'b0; bus.ptr_clr = '0;
    endtask

    task automatic verify(input string nm, input int ch, input logic [31:0] stall_map,
                          input int a0, input int exp_wrap);
        int e_iss[NF];
        int n;
        n = 0;
        for (int i = 0; i < 32 && n < NF; i++)
            if (!stall_map[i]) begin e_iss[n] = acc_cyc + 1 + i; n++; end
        check({nm, " timeout"}, timed_out, 0);
        check({nm, " issue_count"}, addr_q.size(), NF);
        check({nm, " rd_count"}, rd_cyc.size(), NF);
        if (addr_q.size() == NF && rd_cyc.size() == NF) begin
            for (int k = 0; k < NF; k++) begin
                check({nm, " bram_addr"}, addr_q[k], a0 + k);
                check({nm, " issue_cycle"}, iss_cyc[k], e_iss[k]);
                check({nm, " rd_cycle"}, rd_cyc[k], e_iss[k] + RL);
                check({nm, " rd_ch"}, rd_ch_q[k], ch);
                check({nm, " rd_last"}, rd_last_q[k], (k == NF - 1) ? 1 : 0);
            end
        end
        check({nm, " done_count"}, done_n, 1);
        check({nm, " done_ch"}, done_ch_v, ch);
        check({nm, " done_cycle"}, done_cyc, e_iss[NF-1] + RL);
        check({nm, " ready_cycle"}, ready_cyc, e_iss[NF-1] + RL + 1);
        check({nm, " wrap_count"}, wrap_n, exp_wrap);
        if (exp_wrap != 0) check({nm, " wrap_cycle"}, wrap_cyc, e_iss[NF-1]);
    endtask

    // Reference: region base plus tile index times beats per tile
    task automatic model_fetch(input int ch, input logic [3:0] clr_last, input logic [3:0] pre_clr,
                               output int a0, output int exp_wrap);
        for (int i = 0; i < NUM_CH; i++) if (pre_clr[i]) mptr[i] = 0;
        a0 = ch * STRIDE + mptr[ch] * NF;
        exp_wrap = (mptr[ch] == NT - 1 && !clr_last[ch]) ? 1 : 0;
        mptr[ch] = (mptr[ch] + 1) % NT;
        for (int i = 0; i < NUM_CH; i++) if (clr_last[i]) mptr[i] = 0;
    endtask

    initial begin
        int a0, ew, ch, bad;
        logic [31:0] sm;
        logic [3:0] cl, pc;

        bus.start_valid = 1'b0; bus.start_ch = '0; bus.ptr_clr = '0; bus.stall = 1'b0;
        tbl.push_back('{0, 32'h0, 4'h0, 4'h0, 0, 0});
        tbl.push_back('{2, 32'h0, 4'h0, 4'h0, 2048, 0});
        tbl.push_back('{2, 32'h0, 4'h0, 4'h0, 2050, 0});
        tbl.push_back('{2, 32'h0, 4'h0, 4'h0, 2052, 0});
        tbl.push_back('{0, 32'hE, 4'h0, 4'h0, 2, 0});
        tbl.push_back('{1, 32'h0, 4'h0, 4'h0, 1024, 0});
        for (int i = 0; i < 5; i++) tbl.push_back('{3, 32'h0, 4'h0, 4'h0, 3072 + 2 * i, 0});
        tbl.push_back('{3, 32'h0, 4'h8, 4'h0, 3082, 0});
        tbl.push_back('{3, 32'h0, 4'h0, 4'h0, 3072, 0});
        tbl.push_back('{0, 32'h0, 4'h0, 4'h0, 4, 0});
        tbl.push_back('{2, 32'h0, 4'h0, 4'h0, 2054, 0});

        repeat (3) @(negedge clk);
        #1;
        check("reset start_ready", bus.start_ready, 1);
        check("reset bram_en", bus.bram_en, 0);
        check("reset bram_addr", bus.bram_addr, 0);
        check("reset rd_valid", bus.rd_valid, 0);
        check("reset fetch_done", bus.fetch_done, 0);
        check("reset wrap", bus.wrap, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            do_fetch(tbl[i].ch, tbl[i].stall_map, tbl[i].clr_last, tbl[i].pre_clr);
            verify($sformatf("vec%0d", i), tbl[i].ch, tbl[i].stall_map, tbl[i].a0, tbl[i].wrap);
        end

        // Channel 1 sits at tile 1: walk it to the last tile, wrap, then restart at 0
        for (int p = 1; p < NT; p++) begin
            do_fetch(1, 32'h0, 4'h0, 4'h0);
            verify($sformatf("walk%0d", p), 1, 32'h0, STRIDE + 2 * p, (p == NT - 1) ? 1 : 0);
        end
        do_fetch(1, 32'h0, 4'h0, 4'h0);
        verify("after_wrap", 1, 32'h0, 1024, 0);

        // Reset during drain with beats still in the return pipe
        @(negedge clk);
        bus.start_valid = 1'b1; bus.start_ch = 2'd1;
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("pre_reset rd_valid", bus.rd_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("inreset rd_valid", bus.rd_valid, 0);
        check("inreset fetch_done", bus.fetch_done, 0);
        check("inreset start_ready", bus.start_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (bus.rd_valid || bus.fetch_done || !bus.start_ready) bad++;
        end
        check("post_reset quiet", bad, 0);
        for (int i = 0; i < NUM_CH; i++) mptr[i] = 0;
        for (int c2 = 0; c2 < NUM_CH; c2++) begin
            do_fetch((c2 + 1) % NUM_CH, 32'h0, 4'h0, 4'h0);
            model_fetch((c2 + 1) % NUM_CH, 4'h0, 4'h0, a0, ew);
            verify($sformatf("post_reset_ch%0d", (c2 + 1) % NUM_CH), (c2 + 1) % NUM_CH, 32'h0, a0, ew);
        end

        for (int r = 0; r < 40; r++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            sm = $urandom & 32'h0000_00FF;
            cl = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            pc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            do_fetch(ch, sm, cl, pc);
            model_fetch(ch, cl, pc, a0, ew);
            verify($sformatf("rand%0d", r), ch, sm, a0, ew);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
